// File: rtl/tb_mem_arbiter_if.sv
// tb_mem_arbiter_if: requester-side bus and RAM port of the testbench data-RAM arbiter.
interface tb_mem_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]              req_i;
    logic [NUM_REQ-1:0]              we_i;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i;
    logic [NUM_REQ-1:0]              gnt_o;
    logic [NUM_REQ-1:0]              rvalid_o;
    logic [DATA_WIDTH-1:0]           rdata_o;
    logic                            ram_en_o;
    logic                            ram_we_o;
    logic [DATA_WIDTH/8-1:0]         ram_be_o;
    logic [ADDR_WIDTH-1:0]           ram_addr_o;
    logic [DATA_WIDTH-1:0]           ram_wdata_o;
    logic [DATA_WIDTH-1:0]           ram_rdata_i;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, ram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, ram_rdata_i,
        output gnt_o, rvalid_o, rdata_o, ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/tb_mem_arbiter.sv
// tb_mem_arbiter: round-robin arbiter sharing one data-RAM port between NUM_REQ OBI-style requesters.
module tb_mem_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk_i,
    input logic             rst_i,
    tb_mem_arbiter_if.slave bus
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    logic [IDX_WIDTH-1:0]   prio_q, resp_idx_q, win;
    logic                   resp_valid_q, hit;
    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [NUM_REQ-1:0]     rot;

    always_comb begin
        req_dbl = {bus.req_i, bus.req_i};
        rot     = NUM_REQ'(req_dbl >> prio_q);
        hit     = 1'b0;
        win     = '0;
        // walk downwards so the smallest offset from prio_q is the final assignment
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i] && !rst_i) begin
                hit = 1'b1;
                win = IDX_WIDTH'((int'(prio_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        bus.gnt_o            = '0;
        bus.gnt_o[win]       = hit;
        bus.ram_en_o         = hit;
        bus.ram_we_o         = hit & bus.we_i[win];
        bus.ram_be_o         = hit ? bus.be_i[int'(win)*BE_WIDTH +: BE_WIDTH] : '0;
        bus.ram_addr_o       = hit ? bus.addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
        bus.ram_wdata_o      = hit ? bus.wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
        bus.rvalid_o             = '0;
        bus.rvalid_o[resp_idx_q] = resp_valid_q;
        bus.rdata_o          = resp_valid_q ? bus.ram_rdata_i : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            resp_valid_q <= hit;
            if (hit) begin
                prio_q     <= (win == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                resp_idx_q <= win;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.gnt_o) && $onehot0(bus.rvalid_o));
endmodule

// File: tb/tb_tb_mem_arbiter.sv
// tb_tb_mem_arbiter: directed and random checks of tb_mem_arbiter against a transaction-level model.
module tb_tb_mem_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0, we = '0;
    logic [3:0]   be[N];
    logic [21:0]  addr[N];
    logic [31:0]  wd[N];
    logic [31:0]  ram[256];
    logic [31:0]  ref_mem[256];
    logic [31:0]  ram_rdata = '0;
    int checks = 0, failures = 0;

    int prio_m = 0;
    logic pend_v = 1'b0, pend_rd = 1'b0;
    int pend_idx = 0;
    logic [31:0] pend_data = '0;

    tb_mem_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(22), .DATA_WIDTH(32)) bus ();
    tb_mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(22), .DATA_WIDTH(32)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.req_i       = req;
    assign bus.we_i        = we;
    assign bus.be_i        = {be[2], be[1], be[0]};
    assign bus.addr_i      = {addr[2], addr[1], addr[0]};
    assign bus.wdata_i     = {wd[2], wd[1], wd[0]};
    assign bus.ram_rdata_i = ram_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // environment RAM: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (bus.ram_en_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be_o[b]) ram[bus.ram_addr_o[9:2]][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
            end else begin
                ram_rdata <= ram[bus.ram_addr_o[9:2]];
            end
        end
    end

    // reference model: first requester at or after the pointer wins; response one cycle later
    always @(negedge clk) begin
        int w;
        logic f;
        logic [2:0] e_rv;
        f = 1'b0;
        w = 0;
        if (!rst)
            for (int k = 0; k < N; k++)
                if (!f && req[(prio_m + k) % N]) begin
                    f = 1'b1;
                    w = (prio_m + k) % N;
                end
        chk("m_gnt", 64'(bus.gnt_o), f ? 64'(1 << w) : 64'd0);
        chk("m_en", 64'(bus.ram_en_o), 64'(f));
        chk("m_we", 64'(bus.ram_we_o), f ? 64'(we[w]) : 64'd0);
        chk("m_be", 64'(bus.ram_be_o), f ? 64'(be[w]) : 64'd0);
        chk("m_addr", 64'(bus.ram_addr_o), f ? 64'(addr[w]) : 64'd0);
        chk("m_wdata", 64'(bus.ram_wdata_o), f ? 64'(wd[w]) : 64'd0);
        e_rv = (!rst && pend_v) ? 3'(1 << pend_idx) : 3'd0;
        chk("m_rvalid", 64'(bus.rvalid_o), 64'(e_rv));
        if (e_rv == 0) chk("m_rdata_idle", 64'(bus.rdata_o), 64'd0);
        else if (pend_rd) chk("m_rdata", 64'(bus.rdata_o), 64'(pend_data));
        if (rst) begin
            prio_m = 0;
            pend_v = 1'b0;
        end else begin
            pend_v = f;
            if (f) begin
                pend_idx  = w;
                pend_rd   = !we[w];
                pend_data = ref_mem[addr[w][9:2]];
                if (we[w])
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[addr[w][9:2]][b*8 +: 8] = wd[w][b*8 +: 8];
                prio_m = (w + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h1000_0000 + i * 32'h0101_0101;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        end
        ram[8'h10] = 32'hAAAA_AAAA; ref_mem[8'h10] = 32'hAAAA_AAAA;
        ram[8'h40] = 32'hDEAD_BEEF; ref_mem[8'h40] = 32'hDEAD_BEEF;
        for (int k = 0; k < N; k++) begin
            be[k] = 4'hF;
            addr[k] = 22'(32'h100 + 4 * k);
            wd[k] = '0;
        end
        req = 3'b111;
        @(negedge clk);
        chk("reset_gnt", 64'(bus.gnt_o), 64'd0);
        chk("reset_en", 64'(bus.ram_en_o), 64'd0);
        chk("reset_rvalid", 64'(bus.rvalid_o), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", 64'(bus.gnt_o), 64'(1 << (i % 3)));
            chk("rr_en", 64'(bus.ram_en_o), 64'd1);
            chk("rr_rvalid", 64'(bus.rvalid_o), i == 0 ? 64'd0 : 64'(1 << ((i - 1) % 3)));
            tick();
            if (i == 5) req = '0;
        end
        @(negedge clk);
        chk("rr_last_rvalid", 64'(bus.rvalid_o), 64'b100);
        tick();
        req = 3'b001;
        addr[0] = 22'h100;
        @(negedge clk);
        chk("rd_gnt", 64'(bus.gnt_o), 64'b001);
        tick();
        req = '0;
        @(negedge clk);
        chk("rd_rvalid", 64'(bus.rvalid_o), 64'b001);
        chk("rd_rdata", 64'(bus.rdata_o), 64'hDEAD_BEEF);
        tick();
        req = 3'b010;
        @(negedge clk);
        chk("wrap_pre_gnt", 64'(bus.gnt_o), 64'b010);
        tick();
        req = 3'b011;
        @(negedge clk);
        chk("wrap_gnt0", 64'(bus.gnt_o), 64'b001);
        tick();
        @(negedge clk);
        chk("wrap_gnt1", 64'(bus.gnt_o), 64'b010);
        tick();
        req = 3'b111;
        @(negedge clk);
        chk("wrap_prio2", 64'(bus.gnt_o), 64'b100);
        tick();
        req = 3'b010; we[1] = 1'b1; be[1] = 4'b0011; addr[1] = 22'h40; wd[1] = 32'h1234_5678;
        @(negedge clk);
        chk("wr_gnt", 64'(bus.gnt_o), 64'b010);
        chk("wr_ram_we", 64'(bus.ram_we_o), 64'd1);
        tick();
        req = 3'b100; we = '0; be[1] = 4'hF; addr[2] = 22'h40;
        @(negedge clk);
        chk("wr_rvalid", 64'(bus.rvalid_o), 64'b010);
        chk("rd2_gnt", 64'(bus.gnt_o), 64'b100);
        tick();
        req = '0;
        @(negedge clk);
        chk("rd2_rvalid", 64'(bus.rvalid_o), 64'b100);
        chk("rd2_rdata", 64'(bus.rdata_o), 64'hAAAA_5678);
        tick();
        req = 3'b100;
        @(negedge clk);
        chk("mr_gnt", 64'(bus.gnt_o), 64'b100);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mr_rvalid", 64'(bus.rvalid_o), 64'd0);
        chk("mr_en", 64'(bus.ram_en_o), 64'd0);
        tick();
        rst = 1'b0;
        req = 3'b110;
        @(negedge clk);
        chk("mr_next_gnt", 64'(bus.gnt_o), 64'b010);
        for (int c = 0; c < 400; c++) begin
            tick();
            rst = ($urandom_range(0, 63) == 0);
            req = 3'($urandom);
            we  = 3'($urandom);
            for (int k = 0; k < N; k++) begin
                be[k]   = 4'($urandom);
                addr[k] = {12'($urandom), 4'b0, 4'($urandom_range(0, 15)), 2'b00};
                wd[k]   = $urandom;
            end
        end
        tick();
        rst = 1'b0;
        req = '0;
        repeat (3) tick();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
